// File: rtl/uart_pkg.sv
// Shared constants for the UART FIFO port: register map, STATUS/CTRL bit
// positions and the transmit FSM encoding.
package uart_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd1;
  localparam logic [2:0] ADDR_CTRL   = 3'd2;
  localparam logic [2:0] ADDR_RXCNT  = 3'd3;

  localparam int ST_RX_NONEMPTY = 0;
  localparam int ST_TX_EMPTY    = 1;
  localparam int ST_TX_FULL     = 2;
  localparam int ST_OVERRUN     = 3;

  localparam int CT_IE_RX   = 0;
  localparam int CT_IE_TX   = 1;
  localparam int CT_IE_OVR  = 2;
  localparam int CT_CLR_OVR = 7;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_WAITB = 2'd2,
    TX_BUSY  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_fifo_port_if.sv
// Host bus of the UART FIFO port: one outstanding access, completed by a
// single-cycle Hready pulse.
interface uart_fifo_port_if #(
  parameter int DW = 8
);
  logic          Hselect;
  logic          Hwrite;
  logic [2:0]    Haddress;
  logic [DW-1:0] Hwritedata;
  logic [DW-1:0] Hreaddata;
  logic          Hready;

  modport master (
    output Hselect, Hwrite, Haddress, Hwritedata,
    input  Hreaddata, Hready
  );

  modport slave (
    input  Hselect, Hwrite, Haddress, Hwritedata,
    output Hreaddata, Hready
  );
endinterface

// File: rtl/uart_fifo_port_sync_fifo.sv
// Single-clock FIFO with natural-wrap pointers; the parent derives full/empty
// from count. Popping when empty is ignored; a push when full lands only with a pop.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int DW    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [DW-1:0]          push_data,
  input  logic                   pop,
  output logic [DW-1:0]          pop_data,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_fifo_port.sv
// UART/keyboard character port: RX FIFO fed by two sources, TX FIFO drained
// by a start/busy handshake FSM, and a small register file on the host bus.
//   state    | meaning
//   TX_IDLE  | waiting for a TX character; pops it into tx_data
//   TX_START | tx_start pulse for one cycle
//   TX_WAITB | waiting for the transmitter to raise tx_busy
//   TX_BUSY  | waiting for tx_busy to fall
module uart_fifo_port
  import uart_pkg::*;
#(
  parameter int RX_DEPTH = 16,
  parameter int TX_DEPTH = 16,
  parameter int DW       = 8
) (
  input  logic            Hclock,
  input  logic            Hreset,
  uart_fifo_port_if.slave bus,
  input  logic            rx_valid,
  input  logic [DW-1:0]   rx_data,
  input  logic            kbd_valid,
  input  logic [DW-1:0]   kbd_data,
  output logic            tx_start,
  output logic [DW-1:0]   tx_data,
  input  logic            tx_busy,
  output logic            irq
);
  localparam int RXAW = $clog2(RX_DEPTH);
  localparam int TXAW = $clog2(TX_DEPTH);

  logic [RXAW:0]  rx_count;
  logic [TXAW:0]  tx_count;
  logic [DW-1:0]  rx_head, tx_head, rx_push_data, tx_push_data;
  logic [DW-1:0]  rd_value, stall_data, hold_data;
  logic           rx_push, rx_pop, rx_full, rx_empty, rx_ovf;
  logic           tx_push, tx_pop, tx_full, tx_empty;
  logic           acc, acc_data_wr, ctrl_wr, stall_pend;
  logic           hold_valid, kbd_drop, overrun;
  logic           ie_rx, ie_tx, ie_ovr;
  tx_state_t      state, state_nxt;

  assign rx_full  = (rx_count == (RXAW+1)'(RX_DEPTH));
  assign rx_empty = (rx_count == '0);
  assign tx_full  = (tx_count == (TXAW+1)'(TX_DEPTH));
  assign tx_empty = (tx_count == '0);

  // A stalled DATA write owns the bus until it lands; new selects are ignored.
  assign acc          = bus.Hselect & ~stall_pend;
  assign acc_data_wr  = acc & bus.Hwrite & (bus.Haddress == ADDR_DATA);
  assign ctrl_wr      = acc & bus.Hwrite & (bus.Haddress == ADDR_CTRL);
  assign rx_pop       = acc & ~bus.Hwrite & (bus.Haddress == ADDR_DATA) & ~rx_empty;
  assign tx_push      = (acc_data_wr | stall_pend) & ~tx_full;
  assign tx_push_data = stall_pend ? stall_data : bus.Hwritedata;

  // UART wins the push slot; a parked keyboard char goes next, a new one only if nothing else.
  assign kbd_drop     = kbd_valid & hold_valid;
  assign rx_push      = rx_valid | hold_valid | kbd_valid;
  assign rx_push_data = rx_valid ? rx_data : (hold_valid ? hold_data : kbd_data);
  assign rx_ovf       = rx_push & rx_full & ~rx_pop;

  sync_fifo #(.DEPTH(RX_DEPTH), .DW(DW)) u_rx_fifo (
    .clk       (Hclock),
    .rst_n     (Hreset),
    .push      (rx_push),
    .push_data (rx_push_data),
    .pop       (rx_pop),
    .pop_data  (rx_head),
    .count     (rx_count)
  );

  sync_fifo #(.DEPTH(TX_DEPTH), .DW(DW)) u_tx_fifo (
    .clk       (Hclock),
    .rst_n     (Hreset),
    .push      (tx_push),
    .push_data (tx_push_data),
    .pop       (tx_pop),
    .pop_data  (tx_head),
    .count     (tx_count)
  );

  always_comb begin
    rd_value = '0;
    case (bus.Haddress)
      ADDR_DATA:   rd_value = rx_empty ? '0 : rx_head;
      ADDR_STATUS: begin
        rd_value[ST_RX_NONEMPTY] = ~rx_empty;
        rd_value[ST_TX_EMPTY]    = tx_empty;
        rd_value[ST_TX_FULL]     = tx_full;
        rd_value[ST_OVERRUN]     = overrun;
      end
      ADDR_CTRL: begin
        rd_value[CT_IE_RX]  = ie_rx;
        rd_value[CT_IE_TX]  = ie_tx;
        rd_value[CT_IE_OVR] = ie_ovr;
      end
      ADDR_RXCNT:  rd_value = DW'(rx_count);
      default:     rd_value = '0;
    endcase
  end

  always_ff @(posedge Hclock or negedge Hreset) begin
    if (!Hreset) begin
      bus.Hready    <= 1'b0;
      bus.Hreaddata <= '0;
      stall_pend    <= 1'b0;
      stall_data    <= '0;
      ie_rx         <= 1'b0;
      ie_tx         <= 1'b0;
      ie_ovr        <= 1'b0;
      overrun       <= 1'b0;
      hold_valid    <= 1'b0;
      hold_data     <= '0;
      irq           <= 1'b0;
    end else begin
      bus.Hready <= 1'b0;
      if (stall_pend) begin
        if (!tx_full) begin
          stall_pend <= 1'b0;
          bus.Hready <= 1'b1;
        end
      end else if (bus.Hselect) begin
        bus.Hreaddata <= bus.Hwrite ? '0 : rd_value;
        if (acc_data_wr && tx_full) begin
          stall_pend <= 1'b1;
          stall_data <= bus.Hwritedata;
        end else begin
          bus.Hready <= 1'b1;
        end
        if (ctrl_wr) begin
          ie_rx  <= bus.Hwritedata[CT_IE_RX];
          ie_tx  <= bus.Hwritedata[CT_IE_TX];
          ie_ovr <= bus.Hwritedata[CT_IE_OVR];
        end
      end

      // A new overrun in the clearing cycle must not be lost.
      if (rx_ovf || kbd_drop)
        overrun <= 1'b1;
      else if (ctrl_wr && bus.Hwritedata[CT_CLR_OVR])
        overrun <= 1'b0;

      if (hold_valid && !rx_valid) begin
        hold_valid <= 1'b0;
      end else if (!hold_valid && rx_valid && kbd_valid) begin
        hold_valid <= 1'b1;
        hold_data  <= kbd_data;
      end

      irq <= (ie_rx & ~rx_empty) | (ie_tx & tx_empty) | (ie_ovr & overrun);
    end
  end

  always_ff @(posedge Hclock or negedge Hreset) begin
    if (!Hreset) begin
      state   <= TX_IDLE;
      tx_data <= '0;
    end else begin
      state <= state_nxt;
      if (tx_pop) tx_data <= tx_head;
    end
  end

  always_comb begin
    state_nxt = state;
    tx_pop    = 1'b0;
    tx_start  = 1'b0;
    case (state)
      TX_IDLE: begin
        if (!tx_empty) begin
          tx_pop    = 1'b1;
          state_nxt = TX_START;
        end
      end
      TX_START: begin
        tx_start  = 1'b1;
        state_nxt = TX_WAITB;
      end
      TX_WAITB: if (tx_busy)  state_nxt = TX_BUSY;
      TX_BUSY:  if (!tx_busy) state_nxt = TX_IDLE;
      default:  state_nxt = TX_IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_fifo_port.sv
// Directed bench for uart_fifo_port: queue-based model of the RX/TX FIFOs and
// registers, a per-cycle compare process, and literal spot checks.
module tb_uart_fifo_port;
  import uart_pkg::*;

  localparam int DW  = 8;
  localparam int RXD = 4;
  localparam int TXD = 2;

  logic          Hclock = 1'b0;
  logic          Hreset = 1'b1;
  logic          rx_valid, kbd_valid, tx_start, tx_busy, irq;
  logic [DW-1:0] rx_data, kbd_data, tx_data;

  always #5 Hclock = ~Hclock;

  uart_fifo_port_if #(.DW(DW)) bus ();

  uart_fifo_port #(.RX_DEPTH(RXD), .TX_DEPTH(TXD), .DW(DW)) dut (
    .Hclock    (Hclock),
    .Hreset    (Hreset),
    .bus       (bus),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .kbd_valid (kbd_valid),
    .kbd_data  (kbd_data),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .irq       (irq)
  );

  int tests = 0;
  int fails = 0;

  // model state
  logic [DW-1:0] m_rx[$];
  logic [DW-1:0] m_tx[$];
  logic          m_ovr = 1'b0;
  logic [2:0]    m_ie  = 3'b000;
  int            m_txw = 0;
  int            m_txs = 0;

  logic          acc_open  = 1'b0;
  logic          acc_read  = 1'b0;
  logic [DW-1:0] exp_rd    = '0;
  logic [DW-1:0] cur_tx    = '0;
  logic          tx_active = 1'b0;

  int busy_len = 3;
  int busy_cnt = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_push(input logic [DW-1:0] c);
    if (m_rx.size() < RXD) m_rx.push_back(c);
    else m_ovr = 1'b1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Hclock);
    #1;
  endtask

  // transmitter: busy for busy_len cycles after each start pulse
  always @(posedge Hclock) begin
    #1;
    if (tx_start) begin
      tx_busy  = 1'b1;
      busy_cnt = busy_len;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) tx_busy = 1'b0;
    end
  end

  always @(negedge Hclock) begin
    if (Hreset) begin
      if (bus.Hready) begin
        if (!acc_open) check("hready_spurious", bus.Hready, 0);
        else begin
          if (acc_read) check("rdata", bus.Hreaddata, exp_rd);
          acc_open = 1'b0;
        end
      end
      if (tx_start) begin
        if (m_tx.size() == 0) check("tx_start_spurious", tx_start, 0);
        else begin
          cur_tx = m_tx.pop_front();
          check("tx_data", tx_data, cur_tx);
          m_txs++;
          tx_active = 1'b1;
        end
      end else if (tx_busy && tx_active) begin
        check("tx_data_hold", tx_data, cur_tx);
      end
    end
  end

  task automatic bus_xfer(input logic wr, input logic [2:0] a, input logic [DW-1:0] wd,
                          input logic rv, input logic [DW-1:0] rvd,
                          output logic [DW-1:0] rd, output int lat);
    logic [DW-1:0] e;
    int pend;
    e = '0;
    pend = m_txw - m_txs;
    if (!wr) begin
      case (a)
        ADDR_DATA:   e = (m_rx.size() != 0) ? m_rx.pop_front() : '0;
        ADDR_STATUS: e = {4'b0, m_ovr, pend >= TXD, pend == 0, m_rx.size() != 0};
        ADDR_CTRL:   e = {5'b0, m_ie};
        ADDR_RXCNT:  e = DW'(m_rx.size());
        default:     e = '0;
      endcase
    end else if (a == ADDR_CTRL) begin
      m_ie = wd[2:0];
      if (wd[7]) m_ovr = 1'b0;
    end else if (a == ADDR_DATA) begin
      m_tx.push_back(wd);
      m_txw++;
    end
    if (rv) m_push(rvd);
    @(posedge Hclock); #1;
    bus.Hselect = 1'b1; bus.Hwrite = wr; bus.Haddress = a; bus.Hwritedata = wd;
    rx_valid = rv; rx_data = rvd;
    acc_open = 1'b1; acc_read = !wr; exp_rd = e;
    @(posedge Hclock); #1;
    bus.Hselect = 1'b0; rx_valid = 1'b0;
    lat = 1;
    while (!bus.Hready && lat < 400) begin
      @(posedge Hclock); #1;
      lat++;
    end
    if (!bus.Hready) check("hready_timeout", bus.Hready, 1);
    rd = bus.Hreaddata;
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [DW-1:0] d);
    int l;
    bus_xfer(1'b0, a, '0, 1'b0, '0, d, l);
    check("rd_latency", l, 1);
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [DW-1:0] wd);
    logic [DW-1:0] d;
    int l;
    bus_xfer(1'b1, a, wd, 1'b0, '0, d, l);
    check("wr_latency", l, 1);
  endtask

  task automatic drive_src(input logic rv, input logic [DW-1:0] rd,
                           input logic kv, input logic [DW-1:0] kd);
    @(posedge Hclock); #1;
    rx_valid = rv; rx_data = rd; kbd_valid = kv; kbd_data = kd;
    @(posedge Hclock); #1;
    rx_valid = 1'b0; kbd_valid = 1'b0;
    if (rv) m_push(rd);
    if (kv) m_push(kd);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    int lat;
    bus.Hselect = 1'b0; bus.Hwrite = 1'b0; bus.Haddress = '0; bus.Hwritedata = '0;
    rx_valid = 1'b0; rx_data = '0; kbd_valid = 1'b0; kbd_data = '0; tx_busy = 1'b0;

    #3 Hreset = 1'b0;
    #1;
    check("rst_hready", bus.Hready, 0);
    check("rst_hreaddata", bus.Hreaddata, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_irq", irq, 0);
    tick(2);
    Hreset = 1'b1;
    tick(2);

    // RX path
    drive_src(1'b1, 8'h41, 1'b0, '0);
    drive_src(1'b1, 8'h42, 1'b0, '0);
    rd_reg(ADDR_DATA, d);   check("rx_first", d, 8'h41);
    rd_reg(ADDR_DATA, d);   check("rx_second", d, 8'h42);
    rd_reg(ADDR_STATUS, d); check("status_drained", d, 8'h02);
    rd_reg(ADDR_DATA, d);   check("rx_empty_read", d, 8'h00);
    rd_reg(ADDR_RXCNT, d);  check("rxcnt_empty", d, 0);

    // simultaneous UART and keyboard
    drive_src(1'b1, 8'h31, 1'b1, 8'h61);
    tick(1);
    rd_reg(ADDR_RXCNT, d);  check("both_count", d, 2);
    rd_reg(ADDR_DATA, d);   check("both_first", d, 8'h31);
    rd_reg(ADDR_DATA, d);   check("both_second", d, 8'h61);

    // overflow and overrun clear
    for (int i = 0; i < 5; i++) drive_src(1'b1, 8'h10 + 8'(i), 1'b0, '0);
    rd_reg(ADDR_RXCNT, d);  check("ovf_count", d, 4);
    rd_reg(ADDR_STATUS, d); check("ovf_status", d, 8'h0B);
    wr_reg(ADDR_CTRL, 8'h80);
    rd_reg(ADDR_STATUS, d); check("ovr_cleared", d, 8'h03);
    rd_reg(ADDR_CTRL, d);   check("ctrl_after_clr", d, 8'h00);
    // pop and push in the same cycle while full: both land, no overrun
    bus_xfer(1'b0, ADDR_DATA, '0, 1'b1, 8'h24, d, lat);
    check("full_popdata", d, 8'h10);
    rd_reg(ADDR_RXCNT, d);  check("full_poppush_count", d, 4);
    rd_reg(ADDR_STATUS, d); check("full_poppush_status", d, 8'h03);
    for (int i = 0; i < 4; i++) rd_reg(ADDR_DATA, d);
    check("drain_last", d, 8'h24);

    // keyboard char arriving while the holding register is occupied
    @(posedge Hclock); #1;
    rx_valid = 1'b1; rx_data = 8'h71; kbd_valid = 1'b1; kbd_data = 8'h72;
    @(posedge Hclock); #1;
    rx_data = 8'h73; kbd_data = 8'h74;
    @(posedge Hclock); #1;
    rx_valid = 1'b0; kbd_valid = 1'b0;
    m_push(8'h71); m_push(8'h73); m_ovr = 1'b1; m_push(8'h72);
    tick(2);
    rd_reg(ADDR_STATUS, d); check("kbd_drop_status", d, 8'h0B);
    rd_reg(ADDR_DATA, d);   check("kbd_order0", d, 8'h71);
    rd_reg(ADDR_DATA, d);   check("kbd_order1", d, 8'h73);
    rd_reg(ADDR_DATA, d);   check("kbd_order2", d, 8'h72);
    wr_reg(ADDR_CTRL, 8'h80);

    // interrupt
    wr_reg(ADDR_CTRL, 8'h01);
    @(posedge Hclock); #1;
    rx_valid = 1'b1; rx_data = 8'h55;
    @(posedge Hclock); #1;
    rx_valid = 1'b0;
    m_push(8'h55);
    check("irq_one_cycle", irq, 0);
    tick(1);
    check("irq_two_cycles", irq, 1);
    rd_reg(ADDR_DATA, d);   check("irq_char", d, 8'h55);
    tick(1);
    check("irq_after_pop", irq, 0);
    wr_reg(ADDR_CTRL, 8'h02);
    tick(1);
    check("irq_tx_empty", irq, 1);
    wr_reg(ADDR_CTRL, 8'h04);
    rd_reg(ADDR_CTRL, d);   check("ctrl_readback", d, 8'h04);
    check("irq_ovr_clear", irq, 0);
    wr_reg(ADDR_CTRL, 8'h00);

    // TX stall behind a long transmission
    busy_len = 100;
    wr_reg(ADDR_DATA, 8'hA1);
    wr_reg(ADDR_DATA, 8'hA2);
    wr_reg(ADDR_DATA, 8'hA3);
    bus_xfer(1'b1, ADDR_DATA, 8'hA4, 1'b0, '0, d, lat);
    check("stall_long", lat > 50, 1);
    check("stall_first_done", m_txs >= 2, 1);
    for (int i = 0; i < 1000 && (m_txs < 4 || tx_busy); i++) tick(1);
    tick(3);
    check("tx_all_started", m_txs, 4);
    rd_reg(ADDR_STATUS, d); check("tx_done_status", d, 8'h02);

    // reset in the middle of a transmission
    drive_src(1'b1, 8'h99, 1'b0, '0);
    wr_reg(ADDR_DATA, 8'hB1);
    wr_reg(ADDR_DATA, 8'hB2);
    for (int i = 0; i < 20 && !tx_busy; i++) tick(1);
    tick(3);
    check("busy_before_reset", tx_busy, 1);
    @(posedge Hclock); #1;
    Hreset = 1'b0;
    m_rx.delete(); m_tx.delete();
    m_ovr = 1'b0; m_ie = 3'b000; m_txw = 0; m_txs = 0;
    tx_active = 1'b0; acc_open = 1'b0;
    #1;
    check("mid_rst_tx_start", tx_start, 0);
    check("mid_rst_tx_data", tx_data, 0);
    check("mid_rst_hready", bus.Hready, 0);
    check("mid_rst_irq", irq, 0);
    tick(2);
    Hreset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("post_rst_no_start", tx_start, 0);
    end
    rd_reg(ADDR_STATUS, d); check("post_rst_status", d, 8'h02);
    rd_reg(ADDR_RXCNT, d);  check("post_rst_rxcnt", d, 0);
    rd_reg(ADDR_DATA, d);   check("post_rst_data", d, 0);
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
